mips_run_controller: RTL and testbench

//  Sequencer in front of the single-cycle MIPS core. Host streams program words over a

---
 rtl/mips_run_controller.sv | 174 +++++++++++++++++
 tb/tb_mips_run_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_controller.sv
// Run sequencer for the single-cycle MIPS core: loads imem, releases core reset, captures stores.
// Optional RUN_TIMEOUT_EN aborts a run once the cycle count reaches MAX_CYCLES.
module mips_run_controller #(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int CNT_W      = 8,
  parameter int MAX_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  input  logic [31:0]       cpu_pc,
  input  logic              cpu_store,
  input  logic [31:0]       cpu_out,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic [CNT_W-1:0]  cycles,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  if (MAX_CYCLES < 1 || MAX_CYCLES >= (1 << CNT_W)) begin : g_chk
    $error("MAX_CYCLES must fit in the cycle counter");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              full_q, full_d;
  logic              restart_q, restart_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              tmo_q, tmo_d;

  logic              xfer;
  logic [ADDR_W-1:0] eff_ptr;
  logic              pc_hit;

  assign ld_ready = (state_q != RUN) && !full_q;
  assign xfer     = ld_valid && ld_ready;
  // restart_q marks that the next accepted word begins a new program at address 0
  assign eff_ptr  = restart_q ? '0 : wr_ptr_q;
  assign pc_hit   = (cpu_pc == 32'(prog_len_q));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    full_d       = full_q;
    restart_d    = restart_q;
    imem_we_d    = xfer;
    imem_addr_d  = xfer ? eff_ptr : imem_addr_q;
    imem_wdata_d = xfer ? ld_data : imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    result_d     = result_q;
    cycles_d     = cycles_q;
    tmo_d        = tmo_q;
    case (state_q)
      IDLE, DONE: begin
        if (xfer) begin
          state_d   = IDLE;
          wr_ptr_d  = eff_ptr + 1'b1;
          restart_d = 1'b0;
          if (restart_q) begin
            // a new program invalidates the resident one until its last word arrives
            done_d     = 1'b0;
            result_d   = '0;
            prog_len_d = '0;
          end
          if (ld_last || eff_ptr == ADDR_W'(IMEM_DEPTH - 1)) begin
            prog_len_d = {1'b0, eff_ptr} + 1'b1;
            full_d     = 1'b1;
          end
        end else if (start && prog_len_q != '0) begin
          state_d     = RUN;
          cpu_reset_d = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          cycles_d    = '0;
          tmo_d       = 1'b0;
          full_d      = 1'b0;
          restart_d   = 1'b1;
        end
      end
      RUN: begin
        if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
        if (cpu_store) result_d = cpu_out;
        if (pc_hit) begin
          state_d     = DONE;
          cpu_reset_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
`ifdef RUN_TIMEOUT_EN
        else if (cycles_q == CNT_W'(MAX_CYCLES)) begin
          state_d     = DONE;
          cpu_reset_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          tmo_d       = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      prog_len_q   <= '0;
      full_q       <= 1'b0;
      restart_q    <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      cycles_q     <= '0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      full_q       <= full_d;
      restart_q    <= restart_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      cycles_q     <= cycles_d;
      tmo_q        <= tmo_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign cycles     = cycles_q;
`ifdef RUN_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed + randomized bench for mips_run_controller with a behavioural core model.
module tb_mips_run_controller;
  localparam int AW = 4, CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1, ld_valid = 1'b0, ld_last = 1'b0, start = 1'b0;
  logic [31:0] ld_data = '0;
  logic ld_ready, imem_we, cpu_reset, cpu_store, busy, done, timeout_err;
  logic [31:0] imem_wdata, cpu_pc, cpu_out, result;
  logic [AW-1:0] imem_addr;
  logic [CW-1:0] cycles;

  int checks = 0, failures = 0;
  int core_k = 0;
  bit stuck = 1'b0;
  logic [15:0] st_mask = '0;
  logic [31:0] st_val [16];
  logic [31:0] prog [16];
  logic [31:0] model_result = '0;

  mips_run_controller #(.IMEM_DEPTH(16), .ADDR_W(AW), .CNT_W(CW), .MAX_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .cpu_store(cpu_store),
    .cpu_out(cpu_out), .busy(busy), .done(done), .result(result), .cycles(cycles),
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  // Core model: instruction k executes in the k-th cycle out of reset; its PC output
  // already points past it, so the last instruction coincides with cpu_pc==length.
  always @(posedge clk) core_k <= (cpu_reset !== 1'b0) ? 0 : core_k + 1;
  assign cpu_pc    = (cpu_reset !== 1'b0) ? 32'd0 : stuck ? 32'd2 : 32'(core_k + 1);
  assign cpu_store = (cpu_reset === 1'b0) && (core_k < 16) && st_mask[core_k[3:0]];
  assign cpu_out   = st_val[core_k[3:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = last && (i == n - 1);
      chk("ld_ready_pre", {31'b0, ld_ready}, 32'd1);
      step();
      chk("imem_we", {31'b0, imem_we}, 32'd1);
      chk("imem_addr", {28'b0, imem_addr}, 32'(i));
      chk("imem_wdata", imem_wdata, prog[i]);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    model_result = '0;
    step();
    chk("imem_we_idle", {31'b0, imem_we}, 32'd0);
    chk("ld_ready_post", {31'b0, ld_ready}, (last || n == 16) ? 32'd0 : 32'd1);
  endtask

  task automatic run_prog(input int n);
    logic [31:0] exp_res;
    int w;
    exp_res = model_result;
    for (int k = 0; k < n; k++) if (st_mask[k]) exp_res = st_val[k];
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    chk("run_busy", {31'b0, busy}, 32'd1);
    chk("run_ld_ready", {31'b0, ld_ready}, 32'd0);
    w = 0;
    while (done !== 1'b1 && w < 200) begin
      step();
      w++;
    end
    chk("run_bound", {31'b0, (w < 200)}, 32'd1);
    chk("done", {31'b0, done}, 32'd1);
    chk("busy_end", {31'b0, busy}, 32'd0);
    chk("cpu_reset_end", {31'b0, cpu_reset}, 32'd1);
    chk("result", result, exp_res);
    chk("cycles", {24'b0, cycles}, 32'(n));
    chk("timeout_err", {31'b0, timeout_err}, 32'd0);
    model_result = exp_res;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) st_val[i] = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("rst_imem_we", {31'b0, imem_we}, 32'd0);
    chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cycles", {24'b0, cycles}, 32'd0);

    // start with no program is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("empty_start_busy", {31'b0, busy}, 32'd0);
    chk("empty_start_cpu_reset", {31'b0, cpu_reset}, 32'd1);

    // directed five-word program storing 15 from word 4
    prog[0] = 32'h20010005; prog[1] = 32'h2002000A; prog[2] = 32'h00221820;
    prog[3] = 32'h00602020; prog[4] = 32'hAC040000;
    load(5, 1'b1);
    st_mask = 16'h0010;
    st_val[4] = 32'd15;
    run_prog(5);
    step();
    chk("done_held", {31'b0, done}, 32'd1);
    // re-run the resident program without reloading
    run_prog(5);

    // start and ld_valid together in DONE: load wins
    ld_valid = 1'b1; ld_data = 32'h1234_5678; start = 1'b1;
    step();
    ld_valid = 1'b0; start = 1'b0;
    chk("coinc_we", {31'b0, imem_we}, 32'd1);
    chk("coinc_addr", {28'b0, imem_addr}, 32'd0);
    chk("coinc_done", {31'b0, done}, 32'd0);
    chk("coinc_result", result, 32'd0);
    step();
    chk("coinc_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("coinc_busy", {31'b0, busy}, 32'd0);

    // reset during the third run cycle
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 5; i++) prog[i] = $urandom;
    load(5, 1'b1);
    st_mask = 16'h0001;
    st_val[0] = 32'h0000_ABCD;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("pre_rst_result", result, 32'h0000_ABCD);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrun_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("midrun_busy", {31'b0, busy}, 32'd0);
    chk("midrun_done", {31'b0, done}, 32'd0);
    chk("midrun_result", result, 32'd0);
    chk("midrun_cycles", {24'b0, cycles}, 32'd0);
    model_result = '0;

    // full 16-word program without ld_last
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    load(16, 1'b0);
    ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    chk("full_no_we", {31'b0, imem_we}, 32'd0);
    st_mask = 16'h8001;
    st_val[0] = 32'h1111_1111; st_val[15] = 32'h2222_2222;
    run_prog(16);

    // randomized programs and store patterns
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      for (int i = 0; i < 16; i++) st_val[i] = $urandom;
      st_mask = 16'($urandom);
      load(n, (n == 16) ? 1'($urandom) : 1'b1);
      run_prog(n);
    end

`ifdef RUN_TIMEOUT_EN
    // PC stuck below the program length: aborted once cycles reaches 8
    for (int i = 0; i < 5; i++) prog[i] = $urandom;
    load(5, 1'b1);
    st_mask = 16'h0000;
    stuck = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("tmo_cycles8", {24'b0, cycles}, 32'd8);
    chk("tmo_still_run", {31'b0, cpu_reset}, 32'd0);
    step();
    chk("tmo_done", {31'b0, done}, 32'd1);
    chk("tmo_err", {31'b0, timeout_err}, 32'd1);
    chk("tmo_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    stuck = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
